warp_fetcher: RTL and testbench

// Per-warp PC/state table at the front of the compute-unit pipeline. Accepts warp launches,

---
 rtl/bgpu_fetch_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/warp_fetcher.sv | 150 +++++++++++++++
 tb/tb_warp_fetcher.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bgpu_fetch_pkg.sv
// Shared types for the warp fetch front end.
package bgpu_fetch_pkg;

  // Lifecycle of one warp slot in the fetch table.
  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    READY    = 2'd1,
    WAITING  = 2'd2
  } warp_state_e;

  // Index width for a table of num_warps entries (at least one bit).
  function automatic int wid_width(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NumReq   = 8,
  parameter int IdxWidth = 3
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic [IdxWidth-1:0] gnt_idx,
  output logic                gnt_valid
);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NumReq;
      if (req[idx]) begin
        gnt_idx   = IdxWidth'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_fetcher.sv
// Per-warp PC/state table: accepts launches, round-robin issues one fetch per
// warp to the instruction cache, and retires/advances warps on decoder feedback.
module warp_fetcher
  import bgpu_fetch_pkg::*;
#(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32,
  parameter int WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [PcWidth-1:0]   launch_pc_i,
  input  logic [WarpWidth-1:0] launch_act_mask_i,
  output logic [WidWidth-1:0]  launch_warp_id_o,
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  input  logic                 dec_decoded_i,
  input  logic                 dec_stop_warp_i,
  input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
  output logic [NumWarps-1:0]  warps_active_o
);

  typedef struct packed {
    warp_state_e          state;
    logic [PcWidth-1:0]   pc;
    logic [WarpWidth-1:0] act_mask;
  } warp_entry_t;

  warp_entry_t          warp_tbl [NumWarps];
  logic [NumWarps-1:0]  ready_vec;
  logic [NumWarps-1:0]  inactive_vec;
  logic [WidWidth-1:0]  launch_id;
  logic [WidWidth-1:0]  rr_ptr;
  logic [WidWidth-1:0]  lock_id;
  logic                 lock;
  logic [WidWidth-1:0]  arb_idx;
  logic                 arb_valid;
  logic [WidWidth-1:0]  grant_id;
  logic [WidWidth-1:0]  grant_next;
  logic                 launch_fire;
  logic                 fetch_fire;
  logic                 fb_in_range;
  logic                 fb_hit;

  // Decode per-warp state into request/free vectors.
  always_comb begin
    ready_vec    = '0;
    inactive_vec = '0;
    for (int w = 0; w < NumWarps; w++) begin
      ready_vec[w]    = (warp_tbl[w].state == READY);
      inactive_vec[w] = (warp_tbl[w].state == INACTIVE);
    end
  end

  // Lowest-index free slot is where a launch lands.
  always_comb begin
    launch_id = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (inactive_vec[i]) launch_id = WidWidth'(i);
    end
  end

  rr_arbiter #(
    .NumReq   (NumWarps),
    .IdxWidth (WidWidth)
  ) u_rr_arbiter (
    .req       (ready_vec),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // A stalled request keeps its warp until the cache takes it.
  assign grant_id   = lock ? lock_id : arb_idx;
  assign grant_next = (grant_id == WidWidth'(NumWarps - 1)) ? '0 : grant_id + WidWidth'(1);

  assign launch_ready_o   = |inactive_vec;
  assign launch_warp_id_o = launch_id;
  assign warps_active_o   = ~inactive_vec;

  assign fe_valid_o    = lock | arb_valid;
  assign fe_pc_o       = fe_valid_o ? warp_tbl[grant_id].pc       : '0;
  assign fe_act_mask_o = fe_valid_o ? warp_tbl[grant_id].act_mask : '0;
  assign fe_warp_id_o  = fe_valid_o ? grant_id                    : '0;

  assign launch_fire = launch_valid_i && launch_ready_o;
  assign fetch_fire  = fe_valid_o && ic_ready_i;
  assign fb_in_range = int'(dec_decoded_warp_id_i) < NumWarps;
  assign fb_hit      = dec_decoded_i && fb_in_range &&
                       (warp_tbl[dec_decoded_warp_id_i].state == WAITING);

  // Warp table update: launch, fetch issue and feedback always target
  // warps in different states, so they never collide on one entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the table is reset because the state field defines which warps exist; pc/mask are cleared alongside it.
      for (int i = 0; i < NumWarps; i++) begin
        warp_tbl[i] <= '{state: INACTIVE, pc: '0, act_mask: '0};
      end
    end else begin
      // NOTE: non-blocking assignments so every update sees the pre-edge table.
      if (launch_fire) begin
        warp_tbl[launch_id] <= '{state: READY, pc: launch_pc_i, act_mask: launch_act_mask_i};
      end
      if (fetch_fire) begin
        warp_tbl[grant_id].state <= WAITING;
      end
      if (fb_hit) begin
        if (dec_stop_warp_i) begin
          warp_tbl[dec_decoded_warp_id_i].state    <= INACTIVE;
          warp_tbl[dec_decoded_warp_id_i].act_mask <= '0;
        end else begin
          warp_tbl[dec_decoded_warp_id_i].state <= READY;
          warp_tbl[dec_decoded_warp_id_i].pc    <= dec_decoded_next_pc_i;
        end
      end
    end
  end

  // Arbitration pointer and stall lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (fetch_fire) begin
      rr_ptr <= grant_next;
      lock   <= 1'b0;
    end else if (fe_valid_o) begin
      lock    <= 1'b1;
      lock_id <= grant_id;
    end
  end

  // Feedback for a warp with nothing in flight points at a decoder bug.
  always_ff @(posedge clk_i) begin
    if (!rst_i && dec_decoded_i) begin
      assert (fb_in_range && warp_tbl[dec_decoded_warp_id_i].state == WAITING)
        else $error("warp_fetcher: feedback for warp %0d which is not waiting", dec_decoded_warp_id_i);
    end
  end

endmodule

// File: tb/tb_warp_fetcher.sv
// Directed bench for warp_fetcher with hand-computed expectations.
module tb_warp_fetcher;

  localparam int PcWidth   = 32;
  localparam int NumWarps  = 8;
  localparam int WarpWidth = 32;
  localparam int WidWidth  = 3;

  logic                 clk;
  logic                 rst;
  logic                 launch_valid;
  logic                 launch_ready;
  logic [PcWidth-1:0]   launch_pc;
  logic [WarpWidth-1:0] launch_mask;
  logic [WidWidth-1:0]  launch_wid;
  logic                 ic_ready;
  logic                 fe_valid;
  logic [PcWidth-1:0]   fe_pc;
  logic [WarpWidth-1:0] fe_mask;
  logic [WidWidth-1:0]  fe_wid;
  logic                 dec;
  logic                 dec_stop;
  logic [WidWidth-1:0]  dec_wid;
  logic [PcWidth-1:0]   dec_pc;
  logic [NumWarps-1:0]  active;

  int n_tests = 0;
  int n_fail  = 0;

  warp_fetcher #(
    .PcWidth   (PcWidth),
    .NumWarps  (NumWarps),
    .WarpWidth (WarpWidth)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .launch_valid_i        (launch_valid),
    .launch_ready_o        (launch_ready),
    .launch_pc_i           (launch_pc),
    .launch_act_mask_i     (launch_mask),
    .launch_warp_id_o      (launch_wid),
    .ic_ready_i            (ic_ready),
    .fe_valid_o            (fe_valid),
    .fe_pc_o               (fe_pc),
    .fe_act_mask_o         (fe_mask),
    .fe_warp_id_o          (fe_wid),
    .dec_decoded_i         (dec),
    .dec_stop_warp_i       (dec_stop),
    .dec_decoded_warp_id_i (dec_wid),
    .dec_decoded_next_pc_i (dec_pc),
    .warps_active_o        (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fe_expect(input string tag, input logic [WidWidth-1:0] wid,
                           input logic [PcWidth-1:0] pc, input logic [WarpWidth-1:0] mask);
    check({tag, "_valid"}, 64'(fe_valid), 64'd1);
    check({tag, "_wid"},   64'(fe_wid),   64'(wid));
    check({tag, "_pc"},    64'(fe_pc),    64'(pc));
    check({tag, "_mask"},  64'(fe_mask),  64'(mask));
  endtask

  // Advance one cycle; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; launch_valid = 1'b0; launch_pc = '0; launch_mask = '0;
    ic_ready = 1'b0; dec = 1'b0; dec_stop = 1'b0; dec_wid = '0; dec_pc = '0;
    #2;
    check("rst_fe_valid",     64'(fe_valid),     64'd0);
    check("rst_launch_ready", 64'(launch_ready), 64'd1);
    check("rst_launch_wid",   64'(launch_wid),   64'd0);
    check("rst_active",       64'(active),       64'd0);
    check("rst_fe_pc",        64'(fe_pc),        64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single warp: launch, fetch, feedback, refetch, stop.
    launch_valid = 1'b1; launch_pc = 32'h100; launch_mask = 32'hFFFF_FFFF; ic_ready = 1'b1;
    #1;
    check("t2_launch_wid", 64'(launch_wid), 64'd0);
    step(); launch_valid = 1'b0; #1;
    fe_expect("t2_fetch0", 3'd0, 32'h100, 32'hFFFF_FFFF);
    check("t2_active", 64'(active), 64'h01);
    step(); #1;
    check("t2_waiting_idle", 64'(fe_valid), 64'd0);
    dec = 1'b1; dec_wid = 3'd0; dec_pc = 32'h101; dec_stop = 1'b0;
    step(); dec = 1'b0; #1;
    fe_expect("t2_refetch", 3'd0, 32'h101, 32'hFFFF_FFFF);
    step(); #1;
    dec = 1'b1; dec_stop = 1'b1; dec_wid = 3'd0;
    step(); dec = 1'b0; dec_stop = 1'b0; #1;
    check("t2_stopped_active", 64'(active), 64'h00);

    // Three warps launched back-to-back are fetched in order 0,1,2.
    launch_valid = 1'b1; launch_pc = 32'h10; launch_mask = 32'h1; #1;
    check("t3_lwid0", 64'(launch_wid), 64'd0);
    step(); launch_pc = 32'h20; launch_mask = 32'h3; #1;
    check("t3_lwid1", 64'(launch_wid), 64'd1);
    fe_expect("t3_f0", 3'd0, 32'h10, 32'h1);
    step(); launch_pc = 32'h30; launch_mask = 32'h7; #1;
    check("t3_lwid2", 64'(launch_wid), 64'd2);
    fe_expect("t3_f1", 3'd1, 32'h20, 32'h3);
    step(); launch_valid = 1'b0; #1;
    fe_expect("t3_f2", 3'd2, 32'h30, 32'h7);
    step(); #1;
    check("t3_drained", 64'(fe_valid), 64'd0);
    check("t3_active", 64'(active), 64'h07);

    // Backpressure: warp 0 stalls for 5 cycles while warp 3 launches behind it.
    ic_ready = 1'b0; dec = 1'b1; dec_wid = 3'd0; dec_pc = 32'h14;
    step(); dec = 1'b0;
    launch_valid = 1'b1; launch_pc = 32'h40; launch_mask = 32'hF0; #1;
    check("t4_lwid3", 64'(launch_wid), 64'd3);
    fe_expect("t4_stall_b", 3'd0, 32'h14, 32'h1);
    step(); launch_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      fe_expect("t4_stall", 3'd0, 32'h14, 32'h1);
      step();
    end
    ic_ready = 1'b1; #1;
    fe_expect("t4_release", 3'd0, 32'h14, 32'h1);
    step(); #1;
    fe_expect("t4_next", 3'd3, 32'h40, 32'hF0);
    step(); #1;
    check("t4_active", 64'(active), 64'h0F);

    // Fill the table, ignored launch when full, then free warp 5.
    launch_valid = 1'b1; launch_mask = 32'hFFFF;
    for (int k = 4; k < 8; k++) begin
      launch_pc = 32'(k) << 8; #1;
      check("t5_lwid", 64'(launch_wid), 64'(k));
      step();
    end
    launch_pc = 32'hBAD; #1;
    check("t5_full_ready", 64'(launch_ready), 64'd0);
    check("t5_full_active", 64'(active), 64'hFF);
    step(); launch_valid = 1'b0; #1;
    check("t5_ignored_ready", 64'(launch_ready), 64'd0);
    check("t5_idle", 64'(fe_valid), 64'd0);
    dec = 1'b1; dec_stop = 1'b1; dec_wid = 3'd5;
    step(); dec = 1'b0; dec_stop = 1'b0; #1;
    check("t5_ready_after_stop", 64'(launch_ready), 64'd1);
    check("t5_lwid5", 64'(launch_wid), 64'd5);
    check("t5_active", 64'(active), 64'hDF);

    // Stop of w2 coincides with a launch while full; retry lands on w2.
    launch_valid = 1'b1; launch_pc = 32'h50; launch_mask = 32'hAA;
    step(); launch_valid = 1'b0; #1;
    fe_expect("t6_w5", 3'd5, 32'h50, 32'hAA);
    step(); #1;
    check("t6_idle", 64'(fe_valid), 64'd0);
    dec = 1'b1; dec_stop = 1'b1; dec_wid = 3'd2;
    launch_valid = 1'b1; launch_pc = 32'h77; launch_mask = 32'h55; #1;
    check("t6_same_cycle_ready", 64'(launch_ready), 64'd0);
    step(); dec = 1'b0; dec_stop = 1'b0; #1;
    check("t6_ready", 64'(launch_ready), 64'd1);
    check("t6_lwid2", 64'(launch_wid), 64'd2);
    check("t6_active_gap", 64'(active), 64'hFB);
    step(); launch_valid = 1'b0; #1;
    check("t6_active_full", 64'(active), 64'hFF);
    fe_expect("t6_w2_wrap", 3'd2, 32'h77, 32'h55);

    // Reset in the middle of an outstanding fetch.
    rst = 1'b1; #1;
    check("t1_fe_valid",     64'(fe_valid),     64'd0);
    check("t1_launch_ready", 64'(launch_ready), 64'd1);
    check("t1_active",       64'(active),       64'd0);
    check("t1_fe_pc",        64'(fe_pc),        64'd0);
    step(); rst = 1'b0;
    step(); #1;
    check("t1_post_idle", 64'(fe_valid), 64'd0);
    check("t1_post_lwid", 64'(launch_wid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
